// File: rtl/uart_tx_param.sv
// UART transmitter: start bit appears 1 cycle after acceptance; each bit lasts max(Prescale,1) cycles.
// Requests made while busy are ignored, unless UART_TX_HOLD_EN is defined, which adds a one-word holding register.
module uart_tx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      tx_done,
    output logic                      hold_full
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE = 1;
    localparam logic [BW-1:0] BIT_ONE  = 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_e;

    state_e                    state_q;
    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [BW-1:0]             bit_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic                      par_bit_q;
    logic                      par_en_q;
    logic                      stop2_q;
    logic                      tx_out_q;
    logic                      busy_q;
    logic                      tx_done_q;

    logic                      start_d;
    logic [DATA_WIDTH-1:0]     new_data_d;
    logic                      new_par_en_d;
    logic                      new_par_typ_d;
    logic                      new_stop2_d;
    logic [PRESCALE_WIDTH-1:0] new_p_d;

    logic [PRESCALE_WIDTH-1:0] in_p;
    logic                      last_cnt;
    logic                      last_stop;
    logic                      frame_end;
    logic                      p_is_one;

    assign in_p      = (Prescale == '0) ? P_ONE : Prescale;
    assign last_cnt  = (cnt_q == p_q - P_ONE);
    assign p_is_one  = (p_q == P_ONE);
    assign last_stop = (state_q == S_STOP2) || ((state_q == S_STOP1) && !stop2_q);
    assign frame_end = last_stop && last_cnt;

`ifdef UART_TX_HOLD_EN
    logic                      hold_full_q;
    logic [DATA_WIDTH-1:0]     hold_data_q;
    logic                      hold_par_en_q;
    logic                      hold_par_typ_q;
    logic                      hold_stop2_q;
    logic [PRESCALE_WIDTH-1:0] hold_p_q;
    logic                      from_hold;
    logic                      hold_load;

    assign from_hold = frame_end && hold_full_q;
    // A request landing on the last stop cycle with the holder empty chains straight into the next frame.
    assign hold_load = Data_Valid && busy_q && !hold_full_q && !frame_end;

    always_comb begin
        start_d       = from_hold || (Data_Valid && (!busy_q || (frame_end && !hold_full_q)));
        new_data_d    = P_DATA;
        new_par_en_d  = PAR_EN;
        new_par_typ_d = PAR_TYP;
        new_stop2_d   = STOP2;
        new_p_d       = in_p;
        if (from_hold) begin
            new_data_d    = hold_data_q;
            new_par_en_d  = hold_par_en_q;
            new_par_typ_d = hold_par_typ_q;
            new_stop2_d   = hold_stop2_q;
            new_p_d       = hold_p_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_full_q    <= 1'b0;
            hold_data_q    <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_typ_q <= 1'b0;
            hold_stop2_q   <= 1'b0;
            hold_p_q       <= P_ONE;
        end else if (hold_load) begin
            hold_full_q    <= 1'b1;
            hold_data_q    <= P_DATA;
            hold_par_en_q  <= PAR_EN;
            hold_par_typ_q <= PAR_TYP;
            hold_stop2_q   <= STOP2;
            hold_p_q       <= in_p;
        end else if (from_hold) begin
            hold_full_q    <= 1'b0;
        end
    end

    assign hold_full = hold_full_q;
`else
    always_comb begin
        start_d       = Data_Valid && !busy_q;
        new_data_d    = P_DATA;
        new_par_en_d  = PAR_EN;
        new_par_typ_d = PAR_TYP;
        new_stop2_d   = STOP2;
        new_p_d       = in_p;
    end

    assign hold_full = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            p_q       <= P_ONE;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (start_d) begin
                state_q   <= S_START;
                cnt_q     <= '0;
                bit_q     <= '0;
                p_q       <= new_p_d;
                shift_q   <= new_data_d;
                par_bit_q <= (^new_data_d) ^ new_par_typ_d;
                par_en_q  <= new_par_en_d;
                stop2_q   <= new_stop2_d;
                tx_out_q  <= 1'b0;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_out_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                    S_START: begin
                        if (last_cnt) begin
                            state_q  <= S_DATA;
                            cnt_q    <= '0;
                            bit_q    <= '0;
                            tx_out_q <= shift_q[0];
                        end else begin
                            cnt_q <= cnt_q + P_ONE;
                        end
                    end
                    S_DATA: begin
                        if (!last_cnt) begin
                            cnt_q <= cnt_q + P_ONE;
                        end else begin
                            cnt_q <= '0;
                            if (bit_q != BIT_LAST) begin
                                bit_q    <= bit_q + BIT_ONE;
                                shift_q  <= shift_q >> 1;
                                tx_out_q <= shift_q[1];
                            end else if (par_en_q) begin
                                state_q  <= S_PARITY;
                                tx_out_q <= par_bit_q;
                            end else begin
                                state_q   <= S_STOP1;
                                tx_out_q  <= 1'b1;
                                tx_done_q <= !stop2_q && p_is_one;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (last_cnt) begin
                            state_q   <= S_STOP1;
                            cnt_q     <= '0;
                            tx_out_q  <= 1'b1;
                            tx_done_q <= !stop2_q && p_is_one;
                        end else begin
                            cnt_q <= cnt_q + P_ONE;
                        end
                    end
                    S_STOP1: begin
                        if (!last_cnt) begin
                            cnt_q     <= cnt_q + P_ONE;
                            tx_done_q <= !stop2_q && (cnt_q + P_ONE == p_q - P_ONE);
                        end else if (stop2_q) begin
                            state_q   <= S_STOP2;
                            cnt_q     <= '0;
                            tx_done_q <= p_is_one;
                        end else begin
                            state_q  <= S_IDLE;
                            cnt_q    <= '0;
                            busy_q   <= 1'b0;
                            tx_out_q <= 1'b1;
                        end
                    end
                    S_STOP2: begin
                        if (!last_cnt) begin
                            cnt_q     <= cnt_q + P_ONE;
                            tx_done_q <= (cnt_q + P_ONE == p_q - P_ONE);
                        end else begin
                            state_q  <= S_IDLE;
                            cnt_q    <= '0;
                            busy_q   <= 1'b0;
                            tx_out_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        tx_out_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign TX_OUT  = tx_out_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: table of hand-computed frames plus reset, ignore and hold sequences.
module tb_uart_tx_param;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic [7:0] Prescale = 8'd1;
    logic       TX_OUT;
    logic       busy;
    logic       tx_done;
    logic       hold_full;

    int total = 0;
    int bad   = 0;

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .busy(busy), .tx_done(tx_done), .hold_full(hold_full)
    );

    always #5 CLK = ~CLK;

    // seq holds the line bits in send order, first bit in the MSB of the low nbits.
    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        s2;
        logic [7:0]  presc;
        logic [15:0] seq;
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int inject_at);
        int p;
        int len;
        logic [2:0] exp3;
        p   = (v.presc == 8'd0) ? 1 : int'(v.presc);
        len = v.nbits * p;
        @(negedge CLK);
        P_DATA = v.data; PAR_EN = v.pe; PAR_TYP = v.pt; STOP2 = v.s2; Prescale = v.presc;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA = ~v.data; PAR_EN = ~v.pe; PAR_TYP = ~v.pt; STOP2 = ~v.s2; Prescale = v.presc + 8'd3;
        for (int c = 0; c < len; c++) begin
            exp3 = {v.seq[v.nbits - 1 - c / p], 1'b1, (c == len - 1)};
            chk($sformatf("%s cyc%0d {tx,busy,done}", v.name, c), {29'd0, TX_OUT, busy, tx_done}, {29'd0, exp3});
            if (c == inject_at) begin
                Data_Valid = 1'b1;
                P_DATA = 8'h3C;
            end else begin
                Data_Valid = 1'b0;
            end
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        chk($sformatf("%s idle after", v.name), {29'd0, TX_OUT, busy, tx_done}, 32'b100);
    endtask

    initial begin
        int dones;
        int stray;
        logic [19:0] hseq;

        vecs[0] = '{"a5_p1",      8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 16'b0101001011,   10};
        vecs[1] = '{"07_p4_even", 8'h07, 1'b1, 1'b0, 1'b1, 8'd4, 16'b011100000111, 12};
        vecs[2] = '{"07_p4_odd",  8'h07, 1'b1, 1'b1, 1'b1, 8'd4, 16'b011100000011, 12};
        vecs[3] = '{"01_p0",      8'h01, 1'b0, 1'b0, 1'b0, 8'd0, 16'b0100000001,   10};
        vecs[4] = '{"55_p2_odd",  8'h55, 1'b1, 1'b1, 1'b0, 8'd2, 16'b01010101011,  11};
        vecs[5] = '{"3c_p3_s2",   8'h3C, 1'b0, 1'b0, 1'b1, 8'd3, 16'b00011110011,  11};

        repeat (3) @(negedge CLK);
        chk("reset {tx,busy,done,hold}", {28'd0, TX_OUT, busy, tx_done, hold_full}, 32'b1000);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], -1);

`ifndef UART_TX_HOLD_EN
        // Request during a frame must not produce a second frame.
        run_vec(vecs[0], 4);
        stray = 0;
        repeat (20) begin
            @(negedge CLK);
            if (busy || !TX_OUT || tx_done) stray++;
        end
        chk("ignored request stray cycles", stray, 0);
`endif

        // Reset during data bit 3 of 0x55 (line index 4).
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 8'd1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre-reset d3 {tx,busy}", {30'd0, TX_OUT, busy}, 32'b01);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid-frame reset {tx,busy,done}", {29'd0, TX_OUT, busy, tx_done}, 32'b100);
        RST = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge CLK);
            if (tx_done || busy || !TX_OUT) dones++;
        end
        chk("no activity after reset", dones, 0);
        run_vec(vecs[4], -1);

`ifdef UART_TX_HOLD_EN
        // 0x11 then 0x22 back-to-back, 0x33 dropped.
        hseq = 20'b0100010001_0010001001;
        @(negedge CLK);
        P_DATA = 8'h11; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 8'd1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("hold cyc%0d {tx,busy}", c), {30'd0, TX_OUT, busy}, {30'd0, hseq[19 - c], 1'b1});
            if (tx_done) dones++;
            if (c == 3) chk("hold_full set", {31'd0, hold_full}, 32'd1);
            if (c == 10) chk("hold_full cleared", {31'd0, hold_full}, 32'd0);
            Data_Valid = 1'b0;
            if (c == 2) begin Data_Valid = 1'b1; P_DATA = 8'h22; end
            if (c == 4) begin Data_Valid = 1'b1; P_DATA = 8'h33; end
            @(negedge CLK);
        end
        chk("hold tx_done pulses", dones, 2);
        stray = 0;
        repeat (15) begin
            if (busy || !TX_OUT || hold_full) stray++;
            @(negedge CLK);
        end
        chk("hold dropped 0x33", stray, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
